// File: rtl/regfile_writeback_arbiter.sv
// Register-file write port arbiter: the ALU path wins every cycle, and mul/div results
// wait in an in-order FIFO. Each FIFO entry has a live bit that a younger ALU write clears.
module regfile_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_wr_en,
  input  logic [4:0]       alu_wr_reg,
  input  logic [31:0]      alu_wr_data,
  input  logic             md_valid,
  output logic             md_ready,
  input  logic [4:0]       md_wr_reg,
  input  logic [31:0]      md_wr_data,
  output logic             reg_write,
  output logic [4:0]       write_reg,
  output logic [31:0]      write_data,
  output logic [31:0]      pending_mask,
  output logic [PTR_W:0]   fifo_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [4:0]       fifo_reg  [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] live_reg;
  logic [DEPTH-1:0] live_next;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [31:0]      entry_onehot [DEPTH];

  logic alu_eff;
  logic md_accept;
  logic push;
  logic pop;
  logic in_live;

  assign alu_eff   = alu_wr_en && (alu_wr_reg != 5'd0);
  assign md_ready  = (count_reg != FULL_CNT);
  assign md_accept = md_valid && md_ready;
  // A register-0 result is accepted but takes no slot.
  assign push      = md_accept && (md_wr_reg != 5'd0);
  assign pop       = !alu_eff && (count_reg != '0);
  // The incoming result is older than a same-edge ALU write to the same register.
  assign in_live   = !(alu_eff && (md_wr_reg == alu_wr_reg));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign live_next[gi] =
          (push && (wr_ptr_reg == PTR_W'(gi))) ? in_live :
          (pop  && (rd_ptr_reg == PTR_W'(gi))) ? 1'b0 :
          (alu_eff && (fifo_reg[gi] == alu_wr_reg)) ? 1'b0 :
          live_reg[gi];
      assign entry_onehot[gi] = live_reg[gi] ? (32'd1 << fifo_reg[gi]) : 32'd0;
    end
  endgenerate

  always_comb begin
    pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_mask = pending_mask | entry_onehot[i];
    end
  end

  assign fifo_count = count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr_reg]  <= md_wr_reg;
      fifo_data[wr_ptr_reg] <= md_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      live_reg <= live_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A squashed head still pops, but only as a bubble; address and data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      write_reg  <= 5'd0;
      write_data <= 32'd0;
    end else if (alu_eff) begin
      reg_write  <= 1'b1;
      write_reg  <= alu_wr_reg;
      write_data <= alu_wr_data;
    end else if (pop && live_reg[rd_ptr_reg]) begin
      reg_write  <= 1'b1;
      write_reg  <= fifo_reg[rd_ptr_reg];
      write_data <= fifo_data[rd_ptr_reg];
    end else begin
      reg_write  <= 1'b0;
    end
  end

endmodule
